// File: rtl/gauss_stream_pkg.sv
// gauss_stream_pkg: binomial kernel coefficients and normalisation shifts for the stream filter
package gauss_stream_pkg;
   localparam int KSIZE_MAX = 5;
   localparam int SHIFT_MAX = 8;
   function automatic int unsigned binom_coef(int k, int i);
      return k == 3 ? (i == 1 ? 2 : 1) : (i == 2 ? 6 : (i == 1 || i == 3) ? 4 : 1);
   endfunction
   function automatic int kernel_shift(int k);
      return k == 3 ? 4 : SHIFT_MAX;
   endfunction
endpackage

// File: rtl/gauss_stream_if.sv
// gauss_stream_if: pixel-in / filtered-pixel-out valid/ready streams; slave is the filter side
interface gauss_stream_if #(
   parameter int DATA_W = 8,
   parameter int ROW_W  = 8,
   parameter int COL_W  = 9
);
   logic              in_valid;
   logic              in_ready;
   logic              in_sof;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ROW_W-1:0]  out_row;
   logic [COL_W-1:0]  out_col;
   modport slave (
      input  in_valid, in_sof, in_data, out_ready,
      output in_ready, out_valid, out_data, out_row, out_col
   );
   modport master (
      output in_valid, in_sof, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_row, out_col
   );
endinterface

// File: rtl/gauss_stream_linebuf.sv
// gauss_stream_linebuf: KSIZE-1 cascaded line memories; registered column read, oldest line at index 0
module gauss_stream_linebuf #(
   parameter int DATA_W      = 8,
   parameter int IMAGE_WIDTH = 320,
   parameter int KSIZE       = 5
) (
   input  logic                               clk,
   input  logic                               en,
   input  logic [$clog2(IMAGE_WIDTH)-1:0]     addr,
   input  logic [DATA_W-1:0]                  wdata,
   output logic [KSIZE-2:0][DATA_W-1:0]       rd
);
   logic [DATA_W-1:0] mem [KSIZE-1][IMAGE_WIDTH];
   // each line moves up one slot at this column: read-before-write ages the column by one row
   always_ff @(posedge clk) begin
      if (en) begin
         for (int j = 0; j < KSIZE - 1; j++) rd[j] <= mem[j][addr];
         for (int j = 0; j < KSIZE - 2; j++) mem[j][addr] <= mem[j+1][addr];
         mem[KSIZE-2][addr] <= wdata;
      end
   end
endmodule

// File: rtl/gauss_stream_filter.sv
// gauss_stream_filter: streaming separable binomial low-pass (KSIZE 3 or 5) with full backpressure.
// Build option: define GAUSS_STREAM_ROUND_EN for round-half-up normalisation instead of truncation.
module gauss_stream_filter
   import gauss_stream_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int IMAGE_WIDTH  = 320,
   parameter int IMAGE_HEIGHT = 240,
   parameter int KSIZE        = 5
) (
   input logic           clk,
   input logic           rst,
   gauss_stream_if.slave s
);
   localparam int ROW_W = $clog2(IMAGE_HEIGHT);
   localparam int COL_W = $clog2(IMAGE_WIDTH);
   localparam int R     = (KSIZE - 1) / 2;
   localparam int SHIFT = kernel_shift(KSIZE);
   localparam int VW    = DATA_W + SHIFT / 2;
   localparam int HW    = DATA_W + SHIFT;

   if ((KSIZE != 3 && KSIZE != 5) || KSIZE > KSIZE_MAX) begin : g_ksize_bad
      $error("gauss_stream_filter: KSIZE must be 3 or 5");
   end

   logic                         stall, adv, acc, last_col, last_row;
   logic [ROW_W-1:0]             row_q, pr, s0_row, s1_row;
   logic [COL_W-1:0]             col_q, pc, s0_col, s1_col;
   logic                         s0_v, s1_v;
   logic [DATA_W-1:0]            d_q, res;
   logic [KSIZE-2:0][DATA_W-1:0] lb_rd;
   logic [KSIZE-1:0][DATA_W-1:0] newest;
   logic [KSIZE-1:0][DATA_W-1:0] win [KSIZE-1];
   logic [KSIZE-1:0][DATA_W-1:0] cur [KSIZE];
   logic [VW-1:0]                vsum_c [KSIZE];
   logic [VW-1:0]                vsum_q [KSIZE];
   logic [HW-1:0]                hsum;

   assign stall      = s.out_valid && !s.out_ready;
   assign adv        = !stall;
   assign s.in_ready = adv;
   assign acc        = s.in_valid && adv;
   assign pr         = s.in_sof ? '0 : row_q;
   assign pc         = s.in_sof ? '0 : col_q;
   assign last_col   = pc == COL_W'(IMAGE_WIDTH - 1);
   assign last_row   = pr == ROW_W'(IMAGE_HEIGHT - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
      end else if (acc) begin
         col_q <= last_col ? '0 : pc + 1'b1;
         row_q <= last_col ? (last_row ? '0 : pr + 1'b1) : pr;
      end
   end

   gauss_stream_linebuf #(
      .DATA_W(DATA_W), .IMAGE_WIDTH(IMAGE_WIDTH), .KSIZE(KSIZE)
   ) u_linebuf (
      .clk(clk), .en(acc), .addr(pc), .wdata(s.in_data), .rd(lb_rd)
   );

   // newest column is the line-buffer read plus the current pixel, both captured on accept
   assign newest = {d_q, lb_rd};

   always_ff @(posedge clk) begin
      if (acc) begin
         d_q <= s.in_data;
         for (int i = 0; i < KSIZE - 2; i++) win[i] <= win[i+1];
         win[KSIZE-2] <= newest;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_v <= 1'b0;
         s1_v <= 1'b0;
      end else if (adv) begin
         s0_v   <= acc && pr >= ROW_W'(KSIZE - 1) && pc >= COL_W'(KSIZE - 1);
         s0_row <= pr - ROW_W'(R);
         s0_col <= pc - COL_W'(R);
         s1_v   <= s0_v;
         s1_row <= s0_row;
         s1_col <= s0_col;
         for (int i = 0; i < KSIZE; i++) vsum_q[i] <= vsum_c[i];
      end
   end

   always_comb begin
      for (int i = 0; i < KSIZE - 1; i++) cur[i] = win[i];
      cur[KSIZE-1] = newest;
      for (int i = 0; i < KSIZE; i++) begin
         vsum_c[i] = '0;
         for (int j = 0; j < KSIZE; j++)
            vsum_c[i] = vsum_c[i] + VW'(binom_coef(KSIZE, j)) * VW'(cur[i][j]);
      end
   end

   always_comb begin
      hsum = '0;
      for (int i = 0; i < KSIZE; i++)
         hsum = hsum + HW'(binom_coef(KSIZE, i)) * HW'(vsum_q[i]);
   end

`ifdef GAUSS_STREAM_ROUND_EN
   logic [HW:0] rnd;
   assign rnd = {1'b0, hsum} + (HW + 1)'(2 ** (SHIFT - 1));
   assign res = DATA_W'(rnd >> SHIFT);
`else
   assign res = DATA_W'(hsum >> SHIFT);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s.out_valid <= 1'b0;
         s.out_data  <= '0;
         s.out_row   <= '0;
         s.out_col   <= '0;
      end else if (adv) begin
         s.out_valid <= s1_v;
         if (s1_v) begin
            s.out_data <= res;
            s.out_row  <= s1_row;
            s.out_col  <= s1_col;
         end
      end
   end
endmodule

// File: tb/tb_gauss_stream_filter.sv
// tb_gauss_stream_filter: directed + random frames against a direct 2-D binomial reference with scoreboard
module tb_gauss_stream_filter;
   localparam int DW = 10, W = 8, H = 6, K = 5, SH = 8, RK = (K - 1) / 2;
   localparam int NOUT = (W - K + 1) * (H - K + 1);
   localparam int RW = $clog2(H), CW = $clog2(W);

   typedef struct { int d; int r; int c; } exp_t;

   logic clk = 1'b0, rst = 1'b1;
   int checks = 0, failures = 0, cyc = 0, nout = 0, mr = 0, mc = 0, bp_until = 0, base = 0;
   bit rnd_ready = 1'b0, rnd_gap = 1'b0, prev_stall = 1'b0;
   int pix [H][W];
   int wt [K] = '{1, 4, 6, 4, 1};
   exp_t sb [$];
   exp_t e;
   logic [DW-1:0] hd;
   logic [RW-1:0] hr;
   logic [CW-1:0] hc;

   gauss_stream_if #(.DATA_W(DW), .ROW_W(RW), .COL_W(CW)) bus ();

   gauss_stream_filter #(
      .DATA_W(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .KSIZE(K)
   ) dut (
      .clk(clk), .rst(rst), .s(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   function automatic int model(int r, int c);
      int s = 0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            s += wt[i] * wt[j] * pix[r-K+1+i][c-K+1+j];
`ifdef GAUSS_STREAM_ROUND_EN
      return (s + (1 << (SH - 1))) >> SH;
`else
      return s >> SH;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // out_ready: forced low during a backpressure window, otherwise high or random
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(negedge clk);
         bus.out_ready = (cyc < bp_until) ? 1'b0 : rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      #2;
      if (rst) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data", bus.out_data, hd);
            chk("hold_row", bus.out_row, hr);
            chk("hold_col", bus.out_col, hc);
         end
         if (bus.out_valid && !bus.out_ready) chk("in_ready_stall", bus.in_ready, 0);
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            assert (sb.size() > 0) else begin
               failures++;
               $error("FAIL unexpected_output observed=(%0d,%0d)=%0d expected=none", bus.out_row, bus.out_col, bus.out_data);
            end
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("out_data", bus.out_data, e.d);
               chk("out_row", bus.out_row, e.r);
               chk("out_col", bus.out_col, e.c);
            end
            nout++;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         hd = bus.out_data;
         hr = bus.out_row;
         hc = bus.out_col;
      end
   end

   task automatic send(input int d, input bit sof);
      int t = 0;
      if (rnd_gap && $urandom_range(0, 1) == 1) begin
         bus.in_valid = 1'b0;
         @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(d);
      bus.in_sof   = sof;
      #1;
      while (!bus.in_ready && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("accept", bus.in_ready, 1);
      if (sof) begin mr = 0; mc = 0; end
      pix[mr][mc] = d;
      if (mr >= K - 1 && mc >= K - 1) sb.push_back('{model(mr, mc), mr - RK, mc - RK});
      mc = (mc == W - 1) ? 0 : mc + 1;
      if (mc == 0) mr = (mr == H - 1) ? 0 : mr + 1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   task automatic send_frame(input int kind, input int npix, input int bp_at, input int lat_at);
      for (int i = 0; i < npix; i++) begin
         int r = i / W, c = i % W;
         int d = kind == 0 ? 100 : kind == 1 ? ((r == 2 && c == 2) ? 255 : 0) : int'($urandom_range(0, (1 << DW) - 1));
         if (i == bp_at) bp_until = cyc + 5;
         send(d, i == 0);
         if (i == lat_at) begin
            #1 chk("lat_edge1", bus.out_valid, 0);
            @(posedge clk);
            #1 chk("lat_edge2", bus.out_valid, 0);
            @(posedge clk);
            #1 chk("lat_edge3", bus.out_valid, 1);
            @(negedge clk);
         end
      end
   endtask

   task automatic drain(input int b);
      int t = 0;
      while (sb.size() > 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      repeat (6) @(negedge clk);
      chk("drain_empty", sb.size(), 0);
      chk("out_count", nout - b, NOUT);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_row", bus.out_row, 0);
      chk("rst_out_col", bus.out_col, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      rst = 1'b0;
      @(negedge clk);
      // constant frame: all outputs 100, first at (2,2), 3 clk after pixel (4,4)
      base = nout;
      send_frame(0, W * H, -1, 4 * W + 4);
      drain(base);
      // impulse
      base = nout;
      send_frame(1, W * H, -1, -1);
      drain(base);
      // 5 clk backpressure mid-line while outputs are flowing
      base = nout;
      send_frame(2, W * H, 4 * W + 5, -1);
      drain(base);
      // random gaps and random downstream ready
      rnd_ready = 1'b1;
      rnd_gap   = 1'b1;
      for (int f = 0; f < 3; f++) begin
         base = nout;
         send_frame(2, W * H, -1, -1);
         drain(base);
      end
      // sof arrives where (3,5) would be: partial frame yields nothing
      base = nout;
      send_frame(2, 3 * W + 5, -1, -1);
      send_frame(2, W * H, -1, -1);
      drain(base);
      // reset with two results in flight
      rnd_ready = 1'b0;
      rnd_gap   = 1'b0;
      repeat (2) @(negedge clk);
      send_frame(2, 4 * W + 6, -1, -1);
      rst = 1'b1;
      sb.delete();
      mr = 0;
      mc = 0;
      @(posedge clk);
      #1;
      chk("rst_mid_out_valid", bus.out_valid, 0);
      chk("rst_mid_out_data", bus.out_data, 0);
      chk("rst_mid_in_ready", bus.in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      base = nout;
      send_frame(2, W * H, -1, -1);
      drain(base);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
